register_dump_unit: RTL and testbench

REGISTER_DUMP_UNIT -- requirements
Module: register_dump_unit

---
 rtl/register_dump_unit.sv | 133 +++++++++++++
 tb/tb_register_dump_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_dump_unit.sv
// rtl/register_dump_unit.sv - streams a register file out MSB byte first over a UART tx_start/tx_done handshake
// Optional DUMP_HEADER_EN: each dump is preceded by an 8'hA5 header byte.
module register_dump_unit #(
   parameter int width  = 32,
   parameter int lenght = 32,
   parameter int NB     = $clog2(lenght)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [width-1:0] rd_data,
   output logic [NB-1:0]    rd_addr,
   output logic [7:0]       tx_data,
   output logic             tx_start,
   input  logic             tx_done,
   output logic             busy,
   output logic             done
);
   localparam int NBYTES = width / 8;
   localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
   localparam logic [NB-1:0]  LAST_REG  = NB'(lenght - 1);

`ifdef DUMP_HEADER_EN
   typedef enum logic [2:0] {IDLE, HEADER, READ, SEND, WAIT_TX, DONE} state_t;
   localparam logic [width-1:0] HDR_WORD = width'(8'hA5) << (width - 8);
   logic hdr_pending;
`else
   typedef enum logic [2:0] {IDLE, READ, SEND, WAIT_TX, DONE} state_t;
`endif

   state_t           state, state_next;
   logic [width-1:0] shift_reg;
   logic [BCW-1:0]   byte_cnt;
   logic             last_byte, last_reg;

   assign last_byte = (byte_cnt == LAST_BYTE);
   assign last_reg  = (rd_addr == LAST_REG);
   // tx_data only changes when a new byte is about to be offered, so it stays stable through WAIT_TX
   assign tx_data   = shift_reg[width-1 -: 8];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      tx_start   = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
`ifdef DUMP_HEADER_EN
            if (start) state_next = HEADER;
`else
            if (start) state_next = READ;
`endif
         end
`ifdef DUMP_HEADER_EN
         HEADER: begin
            tx_start   = 1'b1;
            state_next = WAIT_TX;
         end
`endif
         READ: state_next = SEND;
         SEND: begin
            tx_start   = 1'b1;
            state_next = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
`ifdef DUMP_HEADER_EN
               if (hdr_pending)     state_next = READ;
               else
`endif
               if (!last_byte)      state_next = SEND;
               else if (!last_reg)  state_next = READ;
               else                 state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= '0;
         byte_cnt  <= '0;
         rd_addr   <= '0;
`ifdef DUMP_HEADER_EN
         hdr_pending <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  rd_addr <= '0;
`ifdef DUMP_HEADER_EN
                  shift_reg   <= HDR_WORD;
                  hdr_pending <= 1'b1;
`endif
               end
            end
            READ: begin
               shift_reg <= rd_data;
               byte_cnt  <= '0;
            end
            WAIT_TX: begin
               if (tx_done) begin
`ifdef DUMP_HEADER_EN
                  if (hdr_pending) hdr_pending <= 1'b0;
                  else
`endif
                  if (!last_byte) begin
                     shift_reg <= shift_reg << 8;
                     byte_cnt  <= byte_cnt + BCW'(1);
                  end else if (!last_reg) begin
                     rd_addr <= rd_addr + NB'(1);
                  end
               end
            end
            DONE: rd_addr <= '0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_register_dump_unit.sv
// tb/tb_register_dump_unit.sv - randomized scoreboard bench for register_dump_unit
module tb_register_dump_unit;
   localparam int W = 32;
   localparam int L = 32;
   localparam int NB = 5;
   localparam int TX_LAT = 3;
   localparam int BPR = W / 8;
`ifdef DUMP_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic          clk = 1'b0;
   logic          reset, start, tx_done, tx_start, busy, done;
   logic          uart_done, inj_done;
   logic [W-1:0]  rd_data;
   logic [NB-1:0] rd_addr;
   logic [7:0]    tx_data;
   logic [W-1:0]  regs [L];

   int n_vec = 0;
   int n_err = 0;
   int sent_cnt = 0;
   int done_cnt = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr];
   assign tx_done = uart_done | inj_done;

   register_dump_unit #(.width(W), .lenght(L), .NB(NB)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .rd_data  (rd_data),
      .rd_addr  (rd_addr),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_done  (tx_done),
      .busy     (busy),
      .done     (done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected byte stream of one dump: optional header, then every register big-endian.
   function automatic void push_dump();
      if (HDR == 1) exp_q.push_back(8'hA5);
      for (int r = 0; r < L; r++)
         for (int b = 0; b < BPR; b++)
            exp_q.push_back(8'((regs[r] >> (8 * (BPR - 1 - b))) & 'hFF));
   endfunction

   // UART model: tx_done pulses TX_LAT cycles after the tx_start cycle.
   initial begin
      bit saw;
      int cnt;
      cnt = 0;
      uart_done = 1'b0;
      forever begin
         @(negedge clk);
         saw = tx_start;
         @(posedge clk);
         #1;
         uart_done = 1'b0;
         if (saw) cnt = TX_LAT - 1;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) uart_done = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on each offered byte and checks tx_data holds between offers.
   initial begin
      logic [7:0] last_b;
      bit sent_any;
      sent_any = 0;
      last_b = '0;
      forever begin
         @(negedge clk);
         if (reset) sent_any = 0;
         else begin
            if (tx_start) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL tx_byte: got %0h, expected no byte", tx_data);
               end else check("tx_byte", tx_data, exp_q.pop_front());
               last_b = tx_data;
               sent_any = 1;
               sent_cnt++;
            end else if (busy && sent_any) check("tx_hold", tx_data, last_b);
            if (done) done_cnt++;
         end
      end
   end

   task automatic wait_done(input bit inject, input bit watch, input bit drop_start, output bit ok);
      int nb;
      nb = 0;
      ok = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (inject && c == 0) inj_done = 1'b1;
         if (drop_start && c == 1) start = 1'b0;
         if (c == 3) inj_done = 1'b0;
         if (tx_start) begin
            nb++;
            if (watch && nb == HDR + BPR + 1) check("rd_addr_reg1", rd_addr, 1);
         end
         if (done) begin
            check("rd_addr_no_wrap", rd_addr, L - 1);
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout: got no done pulse, expected one within 2000 cycles");
      end
   endtask

   task automatic dump(input bit inject, input bit hold);
      int base, dc;
      bit ok;
      push_dump();
      if (hold) push_dump();
      base = sent_cnt;
      dc = done_cnt;
      @(posedge clk);
      #1;
      start = 1'b1;
      wait_done(inject, 1, !hold, ok);
      check("bytes_per_dump", sent_cnt - base, HDR + L * BPR);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_rd_addr", rd_addr, 0);
      if (hold) begin
         base = sent_cnt;
         @(negedge clk);
         check("restart_busy", busy, 1);
         start = 1'b0;
         wait_done(0, 0, 0, ok);
         @(negedge clk);
         check("idle_busy2", busy, 0);
      end
      repeat (20) @(negedge clk);
      check("no_extra_bytes", sent_cnt - base, HDR + L * BPR);
      check("queue_drained", exp_q.size(), 0);
      check("done_pulses", done_cnt - dc, hold ? 2 : 1);
   endtask

   initial begin
      int nb, dc, base;
      bit hit;
      reset = 1'b1;
      start = 1'b0;
      inj_done = 1'b0;
      for (int i = 0; i < L; i++) regs[i] = $urandom;
      regs[0]  = 32'h11223344;
      regs[31] = 32'hDEADBEEF;

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_done", done, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_tx_data", tx_data, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      dump(0, 0);

      for (int i = 1; i < L - 1; i++) regs[i] = $urandom;
      dump(1, 0);

      for (int i = 1; i < L - 1; i++) regs[i] = $urandom;
      dump(0, 1);

      // Abandon a dump while waiting on reg 7 byte 2.
      push_dump();
      nb = 0;
      hit = 0;
      @(posedge clk);
      #1;
      start = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (tx_start) nb++;
         if (nb == HDR + 7 * BPR + 3) begin
            hit = 1;
            break;
         end
      end
      check("reached_reg7_byte2", hit, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_tx_start", tx_start, 0);
      check("abort_done", done, 0);
      check("abort_rd_addr", rd_addr, 0);
      check("abort_tx_data", tx_data, 0);
      reset = 1'b0;
      dc = done_cnt;
      base = sent_cnt;
      repeat (10) @(negedge clk);
      check("abort_no_done", done_cnt - dc, 0);
      check("abort_no_bytes", sent_cnt - base, 0);
      check("abort_idle", busy, 0);

      dump(0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
